// File: rtl/play_sequencer_if.sv
// Bundle between the melody playback controller and its environment:
// commands, tempo and song buffer in; note/octave/tone control out.
interface play_sequencer_if #(
  parameter int BUS_W = 301
);
  logic             tick;
  logic             play_pause;
  logic             stop;
  logic             loop_en;
  logic             edit_busy;
  logic [7:0]       song_len;
  logic [BUS_W-1:0] rhyme;
  logic [BUS_W-1:0] md;
  logic [3:0]       note;
  logic [3:0]       octave;
  logic [7:0]       play_pos;
  logic             tone_en;
  logic             playing;
  logic             done;

  modport master (
    output tick, play_pause, stop, loop_en, edit_busy, song_len, rhyme, md,
    input  note, octave, play_pos, tone_en, playing, done
  );

  modport slave (
    input  tick, play_pause, stop, loop_en, edit_busy, song_len, rhyme, md,
    output note, octave, play_pos, tone_en, playing, done
  );
endinterface

// File: rtl/play_sequencer.sv
// Melody playback controller: steps through the note buffer on tempo ticks,
// with play/pause/stop, looping, editor lockout and a per-note articulation gap.
module play_sequencer #(
  parameter int NOTE_TICKS = 1,
  parameter int GAP_CYCLES = 500000,
  parameter int MAX_POS    = 75
) (
  input  logic            clk100mhz,
  input  logic            clr,
  play_sequencer_if.slave bus
);

  localparam int            GW        = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_CYCLES);
  localparam logic [3:0]    TICK_LAST = 4'(NOTE_TICKS - 1);
  localparam logic [7:0]    POS_CAP   = 8'(MAX_POS);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

  state_t        state, state_n;
  logic [7:0]    pos, pos_n, len;
  logic [3:0]    tcnt, tcnt_n;
  logic [GW-1:0] gap, gap_n;
  logic [3:0]    note_n, oct_n;
  logic [8:0]    nib_idx;
  logic          restart, end_song, done_n, tone_n;

  assign len          = (bus.song_len < POS_CAP) ? bus.song_len : POS_CAP;
  assign bus.play_pos = pos;

  always_comb begin
    state_n  = state;
    pos_n    = pos;
    tcnt_n   = tcnt;
    gap_n    = gap;
    restart  = 1'b0;
    end_song = 1'b0;
    done_n   = 1'b0;

    case (state)
      IDLE: begin
        if (!bus.stop && !bus.edit_busy && bus.play_pause && len != 8'd0) begin
          state_n = PLAY;
          pos_n   = '0;
          tcnt_n  = '0;
          restart = 1'b1;
        end
      end
      PLAY: begin
        if (bus.stop) begin
          state_n = IDLE;
          pos_n   = '0;
          tcnt_n  = '0;
          gap_n   = '0;
        end else if (bus.edit_busy || bus.play_pause) begin
          state_n = PAUSE;
        end else begin
          if (gap != GAP_MAX) gap_n = gap + GW'(1);
          if (bus.tick) begin
            if (tcnt == TICK_LAST) begin
              tcnt_n = '0;
              if ({1'b0, pos} + 9'd1 < {1'b0, len}) begin
                pos_n   = pos + 8'd1;
                restart = 1'b1;
              end else begin
                end_song = 1'b1;
              end
            end else begin
              tcnt_n = tcnt + 4'd1;
            end
          end
        end
      end
      PAUSE: begin
        if (bus.stop) begin
          state_n = IDLE;
          pos_n   = '0;
          tcnt_n  = '0;
          gap_n   = '0;
        end else if (!bus.edit_busy && bus.play_pause) begin
          // Song may have been shortened while paused past the current spot.
          if (pos >= len) end_song = 1'b1;
          else            state_n  = PLAY;
        end
      end
      default: state_n = IDLE;
    endcase

    if (end_song) begin
      pos_n  = '0;
      tcnt_n = '0;
      gap_n  = '0;
      if (bus.loop_en) begin
        state_n = PLAY;
        restart = 1'b1;
      end else begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end
    if (restart) gap_n = '0;
  end

  // Note/octave follow the next position so they change with play_pos.
  always_comb begin
    note_n  = '0;
    oct_n   = '0;
    nib_idx = {pos_n[6:0], 2'b00};
    if (pos_n < POS_CAP) begin
      note_n = bus.rhyme[nib_idx +: 4];
      oct_n  = bus.md[nib_idx +: 4];
    end
    tone_n = (state_n == PLAY) && (note_n != 4'd0) && !restart && (gap == GAP_MAX);
  end

  always_ff @(posedge clk100mhz) begin
    if (clr) begin
      state       <= IDLE;
      pos         <= '0;
      tcnt        <= '0;
      gap         <= '0;
      bus.note    <= '0;
      bus.octave  <= '0;
      bus.tone_en <= 1'b0;
      bus.playing <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      state       <= state_n;
      pos         <= pos_n;
      tcnt        <= tcnt_n;
      gap         <= gap_n;
      bus.note    <= note_n;
      bus.octave  <= oct_n;
      bus.tone_en <= tone_n;
      bus.playing <= (state_n == PLAY);
      bus.done    <= done_n;
    end
  end

endmodule

// File: tb/tb_play_sequencer.sv
// Directed bench for play_sequencer: two instances, one with a short gap and
// single-tick notes, one with three ticks per note and no gap.
module tb_play_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_a, clr_b;
  int   total = 0;
  int   bad   = 0;
  int   dcnt;

  play_sequencer_if ia ();
  play_sequencer_if ib ();

  play_sequencer #(.NOTE_TICKS(1), .GAP_CYCLES(2), .MAX_POS(75)) dut_a (
    .clk100mhz(clk), .clr(clr_a), .bus(ia.slave));

  play_sequencer #(.NOTE_TICKS(3), .GAP_CYCLES(0), .MAX_POS(75)) dut_b (
    .clk100mhz(clk), .clr(clr_b), .bus(ib.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_a();
    ia.tick = 1'b1;
    step();
    ia.tick = 1'b0;
  endtask

  task automatic tick_b();
    ib.tick = 1'b1;
    step();
    ib.tick = 1'b0;
  endtask

  task automatic play_a();
    ia.play_pause = 1'b1;
    step();
    ia.play_pause = 1'b0;
  endtask

  task automatic stop_a();
    ia.stop = 1'b1;
    step();
    ia.stop = 1'b0;
  endtask

  int seq[4] = '{1, 2, 0, 3};

  initial begin
    ia.tick = 0; ia.play_pause = 0; ia.stop = 0; ia.loop_en = 0; ia.edit_busy = 0;
    ia.song_len = 0; ia.rhyme = '0; ia.md = '0;
    ib.tick = 0; ib.play_pause = 0; ib.stop = 0; ib.loop_en = 0; ib.edit_busy = 0;
    ib.song_len = 0; ib.rhyme = '0; ib.md = '0;
    clr_a = 1'b1;
    clr_b = 1'b1;
    step();
    step();
    chk("rst_note", ia.note, 0);
    chk("rst_octave", ia.octave, 0);
    chk("rst_pos", ia.play_pos, 0);
    chk("rst_tone", ia.tone_en, 0);
    chk("rst_playing", ia.playing, 0);
    chk("rst_done", ia.done, 0);
    clr_a = 1'b0;
    clr_b = 1'b0;

    // Basic playback: notes 1,2,0,3 with a 2-cycle gap
    for (int i = 0; i < 4; i++) begin
      ia.rhyme[4*i +: 4] = 4'(seq[i]);
      ib.rhyme[4*i +: 4] = 4'(seq[i]);
    end
    ia.song_len = 8'd4;
    play_a();
    chk("start_playing", ia.playing, 1);
    chk("start_pos", ia.play_pos, 0);
    chk("start_note", ia.note, 1);
    chk("start_tone", ia.tone_en, 0);
    step(); chk("gap0_c1", ia.tone_en, 0);
    step(); chk("gap0_c2", ia.tone_en, 0);
    step(); chk("gap0_rise", ia.tone_en, 1);
    for (int k = 1; k < 4; k++) begin
      tick_a();
      chk("seq_pos", ia.play_pos, k);
      chk("seq_note", ia.note, seq[k]);
      chk("seq_tone_drop", ia.tone_en, 0);
      step(); chk("seq_gap_c1", ia.tone_en, 0);
      step(); chk("seq_gap_c2", ia.tone_en, 0);
      step(); chk("seq_tone_rise", ia.tone_en, (seq[k] != 0) ? 1 : 0);
    end
    tick_a();
    chk("end_playing", ia.playing, 0);
    chk("end_pos", ia.play_pos, 0);
    chk("end_done", ia.done, 1);
    step();
    chk("end_done_once", ia.done, 0);

    // Looping over 3 positions
    ia.loop_en = 1'b1;
    ia.song_len = 8'd3;
    play_a();
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick_a();
      if (ia.done === 1'b1) dcnt++;
      chk("loop_pos", ia.play_pos, (k + 1) % 3);
      step();
      if (ia.done === 1'b1) dcnt++;
    end
    chk("loop_no_done", dcnt, 0);
    chk("loop_playing", ia.playing, 1);
    stop_a();
    chk("stop_playing", ia.playing, 0);
    chk("stop_no_done", ia.done, 0);
    ia.loop_en = 1'b0;

    // Pause, edit octave, resume
    ia.song_len = 8'd4;
    ia.rhyme[11:8] = 4'd5;
    play_a();
    tick_a();
    tick_a();
    chk("pause_pre_pos", ia.play_pos, 2);
    play_a();
    chk("pause_playing", ia.playing, 0);
    for (int k = 0; k < 5; k++) begin
      tick_a();
      chk("pause_pos", ia.play_pos, 2);
      chk("pause_tone", ia.tone_en, 0);
    end
    ia.md[11:8] = 4'd2;
    step();
    play_a();
    chk("resume_playing", ia.playing, 1);
    chk("resume_pos", ia.play_pos, 2);
    chk("resume_octave", ia.octave, 2);
    tick_a();
    chk("resume_adv", ia.play_pos, 3);
    stop_a();

    // Editor lockout
    play_a();
    step();
    ia.edit_busy = 1'b1;
    step();
    chk("busy_pause", ia.playing, 0);
    play_a();
    chk("busy_ignore_pp", ia.playing, 0);
    tick_a();
    chk("busy_pos", ia.play_pos, 0);
    ia.edit_busy = 1'b0;
    step();
    step();
    chk("busy_release", ia.playing, 0);
    play_a();
    chk("busy_resume", ia.playing, 1);
    stop_a();

    // Zero length is ignored
    ia.song_len = 8'd0;
    play_a();
    chk("len0_playing", ia.playing, 0);

    // Length clamps to 75 positions
    ia.song_len = 8'd200;
    play_a();
    for (int k = 0; k < 74; k++) tick_a();
    chk("len200_pos", ia.play_pos, 74);
    chk("len200_playing", ia.playing, 1);
    tick_a();
    chk("len200_stop", ia.playing, 0);
    chk("len200_done", ia.done, 1);
    chk("len200_pos0", ia.play_pos, 0);

    // stop + play_pause + tick together
    ia.song_len = 8'd4;
    play_a();
    tick_a();
    chk("combo_pre_pos", ia.play_pos, 1);
    ia.stop = 1'b1; ia.play_pause = 1'b1; ia.tick = 1'b1;
    step();
    ia.stop = 1'b0; ia.play_pause = 1'b0; ia.tick = 1'b0;
    chk("combo_playing", ia.playing, 0);
    chk("combo_pos", ia.play_pos, 0);
    chk("combo_done", ia.done, 0);
    step();
    chk("combo_done_after", ia.done, 0);

    // Instance B: three ticks per note, no gap, reset mid-note
    ib.song_len = 8'd4;
    ib.play_pause = 1'b1; step(); ib.play_pause = 1'b0;
    chk("b_start_tone", ib.tone_en, 0);
    step();
    chk("b_nogap_tone", ib.tone_en, 1);
    tick_b();
    chk("b_tick1_pos", ib.play_pos, 0);
    clr_b = 1'b1;
    step();
    clr_b = 1'b0;
    chk("b_rst_note", ib.note, 0);
    chk("b_rst_octave", ib.octave, 0);
    chk("b_rst_pos", ib.play_pos, 0);
    chk("b_rst_tone", ib.tone_en, 0);
    chk("b_rst_playing", ib.playing, 0);
    chk("b_rst_done", ib.done, 0);
    ib.play_pause = 1'b1; step(); ib.play_pause = 1'b0;
    tick_b(); chk("b_t1_pos", ib.play_pos, 0);
    tick_b(); chk("b_t2_pos", ib.play_pos, 0);
    tick_b(); chk("b_t3_pos", ib.play_pos, 1);
    chk("b_t3_note", ib.note, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/play_sequencer.md
# play_sequencer

Playback controller for the melody buffer that the note editor maintains. It walks the 4-bit note codes in `rhyme` and their octave codes in `md` from position 0 to `song_len`-1, advancing on tempo ticks. For each position it presents the note, octave and a gated tone enable to the tone generator. It provides play/pause/stop and optional looping, and yields to the editor whenever the editor is busy.

## Interface
Parameters:
- `NOTE_TICKS`, default 1: tempo ticks per note position (legal range 1..15).
- `GAP_CYCLES`, default 500000: `clk100mhz` cycles at the start of each note during which `tone_en` is held low (articulation gap); 0 disables the gap.
- `MAX_POS`, default 75: number of addressable positions in a 301-bit buffer (4 bits each).

Ports:
- `clk100mhz` in 1: the only clock.
- `clr` in 1: synchronous reset, active-high.
- `tick` in 1: tempo strobe, one `clk100mhz` cycle wide (derived from 6 Hz).
- `play_pause` in 1: one-cycle command pulse. In IDLE it starts playback; in PLAY it pauses; in PAUSE it resumes.
- `stop` in 1: one-cycle command pulse. Abort and return to IDLE.
- `loop_en` in 1: level. When high, wrap to position 0 after the last position.
- `edit_busy` in 1: level, driven by the editor's `start_`. Forces pause while high.
- `song_len` in 8: number of valid positions.
- `rhyme` in 301: note codes; position i occupies bits [4i+3:4i]. Code 0 means rest.
- `md` in 301: octave codes, same layout. 0 = middle, 1 = low, 2 = high.
- `note` out 4: note code at `play_pos`.
- `octave` out 4: octave code at `play_pos`.
- `play_pos` out 8: current position.
- `tone_en` out 1: tone generator enable.
- `playing` out 1: high in PLAY.
- `done` out 1: one-cycle pulse on normal, non-loop end of song.

## Operation
- States: IDLE, PLAY, PAUSE. Every output is registered.
- Effective length: `len` = min(`song_len`, `MAX_POS`).
- Command priority within a cycle: `clr` > `stop` > `edit_busy` > `play_pause` > `tick`.
- IDLE:
  - `play_pause` with `len`>0 and `edit_busy`=0 goes to PLAY with `play_pos`=0, tick counter 0, gap counter 0.
  - `play_pause` with `len`=0 or `edit_busy`=1 is ignored.
- PLAY:
  - `stop` goes to IDLE.
  - `edit_busy`=1 or `play_pause` goes to PAUSE.
  - On `tick`, the tick counter increments. At `NOTE_TICKS`-1 it clears and the position advances.
- Advance:
  - If `play_pos`+1 < `len`, increment `play_pos` and restart the gap counter.
  - Otherwise, with `loop_en`=1, set `play_pos`=0 and restart the gap counter.
  - Otherwise go to IDLE, set `play_pos`=0, and pulse `done`.
- PAUSE:
  - Position, tick counter and gap counter are frozen.
  - `play_pause` with `edit_busy`=0 resumes PLAY at the same position and counters.
  - `stop` goes to IDLE.
- `len` shrinking below `play_pos`+1 while in PAUSE or PLAY: the next advance or resume takes the end-of-song path (wrap or stop) immediately.
- `note`/`octave` are read live from `rhyme`/`md` at `play_pos` every cycle, so edits made during PAUSE take effect on resume. When `play_pos` ≥ `MAX_POS`, both outputs are 0.
- `tone_en` = (state==PLAY) && (`note`!=0) && (gap counter ≥ `GAP_CYCLES`). The gap counter saturates at `GAP_CYCLES`.

## Timing
- Reset values: state IDLE, `note`=0, `octave`=0, `play_pos`=0, `tone_en`=0, `playing`=0, `done`=0, all counters 0.
- Command latency: 1 cycle. On the edge that samples the command, `playing`, `play_pos`, `note` and `octave` update together.
- Position change:
  - `play_pos`, `note` and `octave` change on the edge that samples the final `tick`.
  - `tone_en` drops on that same edge.
  - `tone_en` rises `GAP_CYCLES`+1 cycles after the position change (only if the note is not 0).
- `done` is high for exactly the one cycle after the edge that enters IDLE from the end of the song. `done` is never asserted by `stop` or `clr`.
- Reset mid-playback: synchronous return to the reset values on the next edge, regardless of any other input.
- `tick` arriving on the same cycle as a state-changing command is discarded.

## Test plan
- Reset, then `play_pause`, `len`=4, `rhyme` positions 0..3 = 1,2,0,3, `GAP_CYCLES`=2, `NOTE_TICKS`=1:
  - `note` sequence 1,2,0,3.
  - `tone_en` low during position 2 and for 3 cycles after each position change.
  - `done` pulses once, ending with `play_pos`=0 and `playing`=0.
- `loop_en`=1, `len`=3: after the 3rd tick `play_pos` returns to 0. `done` stays 0 over 10 ticks.
- Pause/resume:
  - `play_pause` at `play_pos`=2 freezes it; 5 ticks leave `play_pos`=2 and `tone_en`=0.
  - `md` nibble 2 is changed to 2 during the pause.
  - `play_pause` resumes with `octave`=2, and the next tick gives `play_pos`=3.
- `edit_busy` raised in PLAY forces PAUSE in 1 cycle. `play_pause` while `edit_busy`=1 is ignored. Releasing `edit_busy` alone does not resume.
- Boundary conditions:
  - `song_len`=0: `play_pause` ignored.
  - `song_len`=200: play stops after position 74.
  - `stop`+`play_pause`+`tick` in the same cycle: IDLE, no `done`.
- `clr` asserted mid-note with `NOTE_TICKS`=3 after one tick: all outputs return to reset values next cycle. A subsequent play needs 3 ticks to advance.
